// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the five-stage pipeline hazard controller:
//   - sequencer state encodings (RUN / STALL / FLUSH)
//   - EX operand forward-select encodings
//   - bit positions of the control fields carried in the pipeline buffers
//   - a small helper that compares a destination against a source register
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } seq_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;   // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b01;   // EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b10;   // MEM/WB write data

    localparam int SIG_LOAD  = 6;             // mem-to-reg (load) flag
    localparam int SIG_REGWR = 5;             // register write flag

    // Register 0 is hard-wired to zero, so it can never produce a dependency.
    function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline top level and the hazard controller.
//   Pipeline -> controller : register fields and control bytes of the
//                            IF/ID, ID/EX, EX/MEM and MEM/WB buffers,
//                            plus the registered jump flag.
//   Controller -> pipeline : fetch/IF-ID hold, ID/EX bubble, the three
//                            flushes and the two EX forward selects.
// master = pipeline side, slave = hazard controller.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_dest;
    logic [7:0] ex_signals;
    logic [4:0] mem_dest;
    logic [7:0] mem_signals;
    logic       mem_jump;
    logic [4:0] wb_dest;
    logic [7:0] wb_signals;

    logic       pc_hold;
    logic       ifid_hold;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dest, ex_signals,
               mem_dest, mem_signals, mem_jump, wb_dest, wb_signals,
        input  pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dest, ex_signals,
               mem_dest, mem_signals, mem_jump, wb_dest, wb_signals,
        output pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Forward selector for one EX operand.
//   operand            : source register read by the instruction in EX
//   mem_dest/mem_regwr : EX/MEM destination and its write enable
//   wb_dest/wb_regwr   : MEM/WB destination and its write enable
//   sel                : FWD_MEM / FWD_WB / FWD_REG
// EX/MEM wins over MEM/WB because it holds the younger, newer value.
// ---------------------------------------------------------------------------
module fwd_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] operand,
    input  logic [4:0] mem_dest,
    input  logic       mem_regwr,
    input  logic [4:0] wb_dest,
    input  logic       wb_regwr,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_regwr && reg_match(mem_dest, operand)) begin
            sel = FWD_MEM;
        end else if (wb_regwr && reg_match(wb_dest, operand)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage core.
//   clock       : pipeline clock
//   reset       : asynchronous, active-low
//   hz          : hazard_ctrl_if.slave - buffer fields in, hold/bubble/
//                 flush/forward controls out (combinational, same cycle)
//   state       : sequencer state (00 RUN, 01 STALL, 10 FLUSH)
//   stall_count : saturating count of load-use stall cycles
//   flush_count : saturating count of jump flush cycles
// A taken jump in EX/MEM squashes the three younger instructions and takes
// priority over a load-use stall, so hold and flush never hit one buffer in
// the same cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t state_reg;
    seq_state_t state_next;

    logic jump;
    logic luh;
    logic stall_event;

    // Only a few control bits matter here; the rest are carried for other stages.
    logic unused_bits;
    assign unused_bits = ^{hz.ex_signals[7], hz.ex_signals[5:0],
                           hz.mem_signals[7:6], hz.mem_signals[4:0],
                           hz.wb_signals[7:6], hz.wb_signals[4:0]};

    // ---------------- hazard detection ----------------
    assign jump = hz.mem_jump;
    assign luh  = hz.ex_signals[SIG_LOAD] &&
                  (reg_match(hz.ex_dest, hz.id_rs) ||
                   (hz.id_uses_rt && reg_match(hz.ex_dest, hz.id_rt)));
    assign stall_event = luh && !jump;

    // ---------------- operand forwarding ----------------
    logic [4:0] fwd_operand [2];
    logic [1:0] fwd_select  [2];

    assign fwd_operand[0] = hz.ex_rs;
    assign fwd_operand[1] = hz.ex_rt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_sel u_fwd_sel (
            .operand   (fwd_operand[gi]),
            .mem_dest  (hz.mem_dest),
            .mem_regwr (hz.mem_signals[SIG_REGWR]),
            .wb_dest   (hz.wb_dest),
            .wb_regwr  (hz.wb_signals[SIG_REGWR]),
            .sel       (fwd_select[gi])
        );
    end

    assign hz.fwd_a = fwd_select[0];
    assign hz.fwd_b = fwd_select[1];

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- sequencer: next state ----------------
    // In FLUSH the EX/MEM slot was just squashed, so a jump flag seen there
    // is stale and must not start another redirect.
    always_comb begin
        state_next = ST_RUN;
        case (state_reg)
            ST_RUN: begin
                if (jump) begin
                    state_next = ST_FLUSH;
                end else if (luh) begin
                    state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (jump) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // ---------------- sequencer: outputs ----------------
    always_comb begin
        state          = state_reg;
        hz.pc_hold     = stall_event;
        hz.ifid_hold   = stall_event;
        hz.idex_bubble = stall_event;
        hz.ifid_flush  = jump;
        hz.idex_flush  = jump;
        hz.exmem_flush = jump;
    end

    // ---------------- saturating event counters ----------------
    logic             cnt_event [2];
    logic [CNT_W-1:0] cnt_reg   [2];

    assign cnt_event[0] = stall_event;
    assign cnt_event[1] = jump;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_event[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
            end
        end
    end

    assign stall_count = cnt_reg[0];
    assign flush_count = cnt_reg[1];

endmodule
